dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive DMA-loss cycles that force a DMA grant; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 cpu_req / cpu_we  input  1 / 1  memory-stage access request / write enable.
REQ-007 cpu_addr / cpu_wdata  input  AW / DW  memory-stage address / write data.
REQ-008 cpu_gnt  output  1  memory-stage access accepted this cycle.
REQ-009 cpu_stall  output  1  asserted when cpu_req=1 and cpu_gnt=0; freezes the pipeline.
REQ-010 cpu_rvalid / cpu_rdata  output  1 / DW  registered read response for the memory stage.
REQ-011 dma_req / dma_we / dma_lock  input  1 / 1 / 1  loader request / write enable / burst lock.
REQ-012 dma_addr / dma_wdata  input  AW / DW  loader address / write data.
REQ-013 dma_gnt  output  1  loader access accepted this cycle.
REQ-014 dma_rvalid / dma_rdata  output  1 / DW  registered read response for the loader.
REQ-015 mem_we / mem_a / mem_wd  output  1 / AW / DW  single data-memory port: write enable, address, write data.
REQ-016 mem_rd  input  DW  data-memory combinational read data.

Function
REQ-017 Grants are combinational from state and requests; at most one of cpu_gnt and dma_gnt is 1 per cycle.
REQ-018 FSM states: CPU_PRI (reset state), DMA_FORCE, DMA_LOCK.
REQ-019 CPU_PRI: cpu_req wins; dma_gnt = dma_req & ~cpu_req.
REQ-020 DMA_FORCE and DMA_LOCK: dma_req wins; cpu_gnt = cpu_req & ~dma_req.
REQ-021 starve_cnt (4 bits) increments when dma_req=1 and dma_gnt=0, clears when dma_gnt=1 or dma_req=0, and saturates at STARVE_LIMIT.
REQ-022 CPU_PRI -> DMA_FORCE when starve_cnt will reach STARVE_LIMIT at this edge.
REQ-023 DMA_FORCE -> CPU_PRI after one DMA grant, or immediately if dma_req=0.
REQ-024 Any state -> DMA_LOCK at the edge where dma_gnt=1 and dma_lock=1.
REQ-025 DMA_LOCK -> CPU_PRI at the first edge with dma_lock=0 or dma_req=0.
REQ-026 While DMA_LOCK holds and dma_req=1, cpu_gnt stays 0.
REQ-027 Memory port mux: granted requester's address, write data and we drive the port; mem_we = 1 only when granted with we=1.
REQ-028 Memory port with no grant: mem_we=0, mem_a=cpu_addr, mem_wd=cpu_wdata.
REQ-029 Read latency is 1 cycle: a granted read (we=0) sets rvalid=1 for the granted requester in the next cycle, with rdata = mem_rd sampled at the grant edge.
REQ-030 rvalid is a single-cycle pulse; writes produce no rvalid.
REQ-031 rdata holds its last value when rvalid=0.
REQ-032 Write-then-read to the same address on consecutive grants returns the new data, because the memory writes on the edge.

Reset
REQ-033 When rst=0, asynchronously force: state=CPU_PRI, starve_cnt=0, cpu_rvalid=0, dma_rvalid=0, cpu_rdata=0, dma_rdata=0.
REQ-034 During reset, combinational outputs follow REQ-017..REQ-028 using the reset state.
REQ-035 Reset asserted mid-burst or mid-read drops any pending rvalid; there is no replay after release.
REQ-036 First grant after rst rises obeys CPU_PRI.

Verification
REQ-037 Scenario: cpu read only, addr=0x10 holding 0xDEADBEEF -> cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dma_rvalid=0.
REQ-038 Scenario: cpu_req and dma_req held high, STARVE_LIMIT=4 -> cpu granted cycles 0-3, dma granted cycle 4 with cpu_stall=1, cpu granted cycle 5.
REQ-039 Scenario: dma_lock=1 with dma writes to 0x0..0xC, cpu_req=1 throughout -> 4 consecutive dma grants, cpu_stall=1 for all 4 cycles; cpu granted the cycle after dma_lock falls.
REQ-040 Scenario: dma write 0x55 to 0x20, then cpu read 0x20 -> cpu_rdata=0x55 with cpu_rvalid one cycle after cpu_gnt.
REQ-041 Scenario: rst driven low between clock edges during a pending read -> rvalid=0 and state=CPU_PRI immediately, before the next edge.
REQ-042 Scenario: no requests for 10 cycles -> mem_we=0, both rvalid=0, starve_cnt=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline memory stage and a DMA loader.
// The CPU has priority unless the loader has been starved or holds a burst lock.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic          dma_lock,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic [1:0] {
    CPU_PRI   = 2'd0,
    DMA_FORCE = 2'd1,
    DMA_LOCK  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state_r, state_s;
  logic [3:0] starve_cnt_r, starve_cnt_s;

  // Grant decode: requester priority depends only on the current state.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state_r)
      CPU_PRI: begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
      DMA_FORCE, DMA_LOCK: begin
        dma_gnt = dma_req;
        cpu_gnt = cpu_req & ~dma_req;
      end
      default: begin
        cpu_gnt = cpu_req;
        dma_gnt = dma_req & ~cpu_req;
      end
    endcase
    cpu_stall = cpu_req & ~cpu_gnt;
  end

  // Starvation counter and next-state logic.
  always_comb begin
    starve_cnt_s = 4'd0;
    state_s      = state_r;
    if (dma_req && !dma_gnt) begin
      starve_cnt_s = (starve_cnt_r >= LIMIT) ? LIMIT : starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_s = 4'd0;
    end
    // A granted locked access always enters the lock, whatever the current state.
    if (dma_gnt && dma_lock) begin
      state_s = DMA_LOCK;
    end else begin
      case (state_r)
        CPU_PRI: begin
          if (dma_req && !dma_gnt && starve_cnt_s == LIMIT) begin
            state_s = DMA_FORCE;
          end else begin
            state_s = CPU_PRI;
          end
        end
        DMA_FORCE: begin
          if (dma_gnt || !dma_req) begin
            state_s = CPU_PRI;
          end else begin
            state_s = DMA_FORCE;
          end
        end
        DMA_LOCK: begin
          if (!dma_lock || !dma_req) begin
            state_s = CPU_PRI;
          end else begin
            state_s = DMA_LOCK;
          end
        end
        default: state_s = CPU_PRI;
      endcase
    end
  end

  // Memory port mux; an idle port presents the CPU address with writes disabled.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = cpu_addr;
    mem_wd = cpu_wdata;
    if (dma_gnt) begin
      mem_we = dma_we;
      mem_a  = dma_addr;
      mem_wd = dma_wdata;
    end else if (cpu_gnt) begin
      mem_we = cpu_we;
    end else begin
      mem_we = 1'b0;
    end
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= CPU_PRI;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      starve_cnt_r <= starve_cnt_s;
    end
  end

  // Read responses: one-cycle valid pulse, data held between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= {DW{1'b0}};
      dma_rdata  <= {DW{1'b0}};
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= mem_rd;
      end else begin
        cpu_rdata <= cpu_rdata;
      end
      if (dma_gnt && !dma_we) begin
        dma_rdata <= mem_rd;
      end else begin
        dma_rdata <= dma_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a bench-owned memory and a read-response scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;
  logic [31:0] cpu_rdata, dma_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:255];
  bit   [255:0] wr_mask;
  logic [31:0] cpu_q[$], dma_q[$];
  logic [31:0] last_c, last_d;
  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [7:0] i);
    return (i == 8'd4) ? 32'hDEAD_BEEF : {24'hC0FFEE, i};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return wr_mask[a[9:2]] ? mem[a[9:2]] : init_val(a[9:2]);
  endfunction

  assign mem_rd = model_rd(mem_a);

  // Word-addressed memory written on the rising edge.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[9:2]]     <= mem_wd;
      wr_mask[mem_a[9:2]] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic dl,
                        input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_wdata = dd;
  endtask

  // One clock: check combinational outputs, push expected reads, then check responses.
  task automatic cyc(input string tag, input logic exp_cg, input logic exp_dg);
    logic pend_c, pend_d;
    #1;
    chk({tag, ".cpu_gnt"}, cpu_gnt, exp_cg);
    chk({tag, ".dma_gnt"}, dma_gnt, exp_dg);
    chk({tag, ".cpu_stall"}, cpu_stall, cpu_req & ~exp_cg);
    chk({tag, ".mem_we"}, mem_we, (exp_cg & cpu_we) | (exp_dg & dma_we));
    chk({tag, ".mem_a"}, mem_a, exp_dg ? dma_addr : cpu_addr);
    chk({tag, ".mem_wd"}, mem_wd, exp_dg ? dma_wdata : cpu_wdata);
    pend_c = exp_cg & ~cpu_we;
    pend_d = exp_dg & ~dma_we;
    if (pend_c) cpu_q.push_back(model_rd(cpu_addr));
    if (pend_d) dma_q.push_back(model_rd(dma_addr));
    @(posedge clk);
    #1;
    chk({tag, ".cpu_rvalid"}, cpu_rvalid, pend_c);
    chk({tag, ".dma_rvalid"}, dma_rvalid, pend_d);
    if (pend_c && cpu_q.size() > 0) last_c = cpu_q.pop_front();
    if (pend_d && dma_q.size() > 0) last_d = dma_q.pop_front();
    chk({tag, ".cpu_rdata"}, cpu_rdata, last_c);
    chk({tag, ".dma_rdata"}, dma_rdata, last_d);
  endtask

  initial begin
    last_c = 32'd0;
    last_d = 32'd0;
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    chk("rst.cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst.dma_rvalid", dma_rvalid, 1'b0);
    chk("rst.cpu_rdata", cpu_rdata, 32'h0);
    chk("rst.dma_rdata", dma_rdata, 32'h0);
    cpu_req = 1'b1; dma_req = 1'b1;
    #1;
    chk("rst.cpu_gnt", cpu_gnt, 1'b1);
    chk("rst.dma_gnt", dma_gnt, 1'b0);
    cpu_req = 1'b0; dma_req = 1'b0;
    rst = 1'b1;

    repeat (10) cyc("idle", 1'b0, 1'b0);

    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("cpu_rd", 1'b1, 1'b0);
    chk("cpu_rd.const", cpu_rdata, 32'hDEAD_BEEF);
    set_in(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("pulse", 1'b0, 1'b0);

    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h55);
    cyc("dma_wr", 1'b0, 1'b1);
    set_in(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("wr_rd", 1'b1, 1'b0);
    chk("wr_rd.const", cpu_rdata, 32'h55);

    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
    repeat (4) cyc("starve_cpu", 1'b1, 1'b0);
    cyc("starve_dma", 1'b0, 1'b1);
    cyc("starve_back", 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("idle2", 1'b0, 1'b0);

    set_in(1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA0);
    repeat (4) cyc("lock_pre", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      dma_addr = 32'(i * 4);
      dma_wdata = 32'hA0 + 32'(i);
      cyc("lock_burst", 1'b0, 1'b1);
    end
    set_in(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("lock_end", 1'b1, 1'b0);
    chk("lock_end.const", cpu_rdata, 32'hA3);

    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    cyc("lock_rd", 1'b0, 1'b1);
    cpu_req = 1'b1;
    #1;
    chk("lock_hold.cpu_gnt", cpu_gnt, 1'b0);
    chk("lock_hold.dma_rvalid", dma_rvalid, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst.dma_rvalid", dma_rvalid, 1'b0);
    chk("async_rst.dma_rdata", dma_rdata, 32'h0);
    chk("async_rst.cpu_gnt", cpu_gnt, 1'b1);
    chk("async_rst.dma_gnt", dma_gnt, 1'b0);
    last_c = 32'd0;
    last_d = 32'd0;
    #1;
    rst = 1'b1;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
    cyc("post_rst", 1'b1, 1'b0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc("final_idle", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
